// File: rtl/dl_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dl_router                                                    |
// | Description : Routes the hps_io ioctl download stream to one of NUM_TGT    |
// |               memory targets chosen by ioctl_index, buffering bytes in a   |
// |               small FIFO with per-target ready backpressure. Holds the     |
// |               core in reset during and shortly after target-0 downloads.   |
// |               Optional macro DL_CHECKSUM_EN adds a 16-bit running sum of   |
// |               the bytes delivered in the current download.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dl_router #(
  parameter int NUM_TGT    = 4,
  parameter int IN_AW      = 25,
  parameter int OUT_AW     = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_HOLD   = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IN_AW-1:0]    ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  output logic [NUM_TGT-1:0]  tgt_sel,
  output logic                tgt_wr,
  output logic [OUT_AW-1:0]   tgt_addr,
  output logic [7:0]          tgt_data,
  input  logic [NUM_TGT-1:0]  tgt_ready,
  output logic [NUM_TGT-1:0]  dl_active,
  output logic                dl_reset,
  output logic [1:0]          err_flags,
  output logic [15:0]         checksum
);

  localparam int              c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              c_HOLD_W  = $clog2(RST_HOLD + 1);
  localparam int              c_ENTRY_W = OUT_AW + 8;
  localparam logic [c_PTR_W:0]  c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]  c_WAIT_LVL = (c_PTR_W + 1)'(FIFO_DEPTH - 2);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACTIVE  = 3'd1,
    S_DISCARD = 3'd2,
    S_DRAIN   = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   dl_prev_q;
  logic                   pend_q;
  logic [c_HOLD_W-1:0]    hold_cnt_q;
  logic [NUM_TGT-1:0]     tgt_sel_q;
  logic [NUM_TGT-1:0]     dl_active_q;
  logic                   dl_reset_q;
  logic [1:0]             err_q;

  logic [c_ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     wptr_q;
  logic [c_PTR_W-1:0]     rptr_q;
  logic [c_PTR_W:0]       count_q;
  logic [c_PTR_W:0]       count_d;

  logic                   tgt_wr_q;
  logic [OUT_AW-1:0]      tgt_addr_q;
  logic [7:0]             tgt_data_q;

  logic [NUM_TGT-1:0]     w_onehot;
  logic                   w_idx_ok;
  logic                   w_rise;
  logic                   w_start;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ready_sel;
  logic                   w_pop;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_ovf;

  // Decode the incoming index into a one-hot target select.
  for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_onehot
    assign w_onehot[gi] = (32'(ioctl_index) == gi);
  end

  // Address bits above the target window are intentionally discarded.
  if (IN_AW > OUT_AW) begin : g_addr_unused
    logic w_unused;
    assign w_unused = ^ioctl_addr[IN_AW-1:OUT_AW];
  end

  assign w_idx_ok    = (32'(ioctl_index) < NUM_TGT);
  assign w_rise      = ioctl_download & ~dl_prev_q;
  // A rise seen during DRAIN/HOLD is remembered in pend_q and started from IDLE.
  assign w_start     = (state_q == S_IDLE) & ioctl_download & (w_rise | pend_q);

  assign w_full      = (count_q == c_FULL);
  assign w_empty     = (count_q == '0);
  assign w_ready_sel = |(tgt_ready & tgt_sel_q);
  assign w_pop       = ~w_empty & w_ready_sel &
                       ((state_q == S_ACTIVE) | (state_q == S_DRAIN));
  assign w_push_req  = (state_q == S_ACTIVE) & ioctl_wr;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_ovf       = w_push_req & w_full & ~w_pop;

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Download sequencing: target latch, drain, reset hold and sticky errors.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dl_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      hold_cnt_q  <= '0;
      tgt_sel_q   <= '0;
      dl_active_q <= '0;
      dl_reset_q  <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      dl_prev_q <= ioctl_download;

      if (!ioctl_download || w_start) begin
        pend_q <= 1'b0;
      end else if (w_rise && ((state_q == S_DRAIN) || (state_q == S_HOLD))) begin
        pend_q <= 1'b1;
      end

      if (w_ovf) begin
        err_q[0] <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            if (w_idx_ok) begin
              state_q     <= S_ACTIVE;
              tgt_sel_q   <= w_onehot;
              dl_active_q <= w_onehot;
              dl_reset_q  <= (ioctl_index == 8'd0);
            end else begin
              state_q     <= S_DISCARD;
              tgt_sel_q   <= '0;
              err_q[1]    <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (!ioctl_download) begin
            state_q <= S_DRAIN;
          end
        end
        S_DISCARD: begin
          if (!ioctl_download) begin
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_empty && !tgt_wr_q) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == c_HOLD_LAST) begin
            state_q     <= S_IDLE;
            dl_active_q <= '0;
            dl_reset_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      mem_q[wptr_q] <= {ioctl_addr[OUT_AW-1:0], ioctl_dout};
    end
  end

  // FIFO pointers, occupancy and the registered target write port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tgt_wr_q   <= 1'b0;
      tgt_addr_q <= '0;
      tgt_data_q <= '0;
    end else begin
      count_q  <= count_d;
      tgt_wr_q <= w_pop;
      if (w_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_pop) begin
        rptr_q                   <= rptr_q + 1'b1;
        {tgt_addr_q, tgt_data_q} <= mem_q[rptr_q];
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_q;

  // Running sum of delivered bytes, restarted by each new download.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (w_start) begin
      sum_q <= '0;
    end else if (tgt_wr_q) begin
      sum_q <= sum_q + {8'h00, tgt_data_q};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = (count_q >= c_WAIT_LVL) | (state_q == S_DRAIN) | (state_q == S_HOLD);
  assign tgt_sel    = tgt_sel_q;
  assign tgt_wr     = tgt_wr_q;
  assign tgt_addr   = tgt_addr_q;
  assign tgt_data   = tgt_data_q;
  assign dl_active  = dl_active_q;
  assign dl_reset   = dl_reset_q;
  assign err_flags  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dl_router                                                 |
// | Description : Directed, table-driven bench for dl_router.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dl_router;

  localparam int NUM_TGT    = 4;
  localparam int IN_AW      = 25;
  localparam int OUT_AW     = 17;
  localparam int FIFO_DEPTH = 8;
  localparam int RST_HOLD   = 16;

  logic               clk_sys;
  logic               reset_n;
  logic               ioctl_download;
  logic [7:0]         ioctl_index;
  logic               ioctl_wr;
  logic [IN_AW-1:0]   ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic               ioctl_wait;
  logic [NUM_TGT-1:0] tgt_sel;
  logic               tgt_wr;
  logic [OUT_AW-1:0]  tgt_addr;
  logic [7:0]         tgt_data;
  logic [NUM_TGT-1:0] tgt_ready;
  logic [NUM_TGT-1:0] dl_active;
  logic               dl_reset;
  logic [1:0]         err_flags;
  logic [15:0]        checksum;

  dl_router #(
    .NUM_TGT    (NUM_TGT),
    .IN_AW      (IN_AW),
    .OUT_AW     (OUT_AW),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RST_HOLD   (RST_HOLD)
  ) u_dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .tgt_sel        (tgt_sel),
    .tgt_wr         (tgt_wr),
    .tgt_addr       (tgt_addr),
    .tgt_data       (tgt_data),
    .tgt_ready      (tgt_ready),
    .dl_active      (dl_active),
    .dl_reset       (dl_reset),
    .err_flags      (err_flags),
    .checksum       (checksum)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        ewr;
    logic [16:0] eaddr;
    logic [7:0]  edata;
    logic        ewait;
    logic [3:0]  esel;
    logic [3:0]  eact;
    logic        erst;
    logic [1:0]  eerr;
  } vec_t;

  vec_t         vq[$];
  logic [24:0]  got_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [15:0]  exp_ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic add(input logic dl, input logic [7:0] idx, input logic wr,
                     input logic [16:0] addr, input logic [7:0] data, input logic [3:0] rdy,
                     input logic ewr, input logic [16:0] eaddr, input logic [7:0] edata,
                     input logic ewait, input logic [3:0] esel, input logic [3:0] eact,
                     input logic erst, input logic [1:0] eerr);
    vec_t v;
    v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.data = data; v.rdy = rdy;
    v.ewr = ewr; v.eaddr = eaddr; v.edata = edata; v.ewait = ewait;
    v.esel = esel; v.eact = eact; v.erst = erst; v.eerr = eerr;
    vq.push_back(v);
  endtask

  // Step until n target writes are seen or the cycle budget runs out.
  task automatic collect(input int n, input int budget);
    got_q.delete();
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      step();
      if (tgt_wr) got_q.push_back({tgt_addr, tgt_data});
    end
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    repeat (RST_HOLD + 10) step();
  endtask

  initial begin
    `ifdef DL_CHECKSUM_EN
    exp_ck = 16'h0201;
    `else
    exp_ck = 16'h0000;
    `endif

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00; tgt_ready = 4'hF;
    repeat (3) step();
    check("reset_outputs",
          {ioctl_wait, tgt_sel, tgt_wr, tgt_addr, tgt_data, dl_active, dl_reset, err_flags, checksum},
          64'h0);
    reset_n = 1'b1;
    step();

    // Index 1, five bytes with upper address bits set to exercise truncation.
    add(1, 8'd1, 0, 17'd0, 8'h00, 4'hF, 0, 17'd0, 8'h00, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(1, 8'd1, 1, 17'd0, 8'h11, 4'hF, 0, 17'd0, 8'h00, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(1, 8'd1, 1, 17'd1, 8'h12, 4'hF, 1, 17'd0, 8'h11, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(1, 8'd5, 1, 17'd2, 8'h13, 4'hF, 1, 17'd1, 8'h12, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(1, 8'd1, 1, 17'd3, 8'h14, 4'hF, 1, 17'd2, 8'h13, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(1, 8'd1, 1, 17'd4, 8'h15, 4'hF, 1, 17'd3, 8'h14, 0, 4'b0010, 4'b0010, 0, 2'b00);
    add(0, 8'd1, 0, 17'd0, 8'h00, 4'hF, 1, 17'd4, 8'h15, 1, 4'b0010, 4'b0010, 0, 2'b00);
    add(0, 8'd1, 0, 17'd0, 8'h00, 4'hF, 0, 17'd0, 8'h00, 1, 4'b0010, 4'b0010, 0, 2'b00);
    add(0, 8'd1, 0, 17'd0, 8'h00, 4'hF, 0, 17'd0, 8'h00, 1, 4'b0010, 4'b0010, 0, 2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      ioctl_download = vq[i].dl;
      ioctl_index    = vq[i].idx;
      ioctl_wr       = vq[i].wr;
      ioctl_addr     = {8'hA5, vq[i].addr};
      ioctl_dout     = vq[i].data;
      tgt_ready      = vq[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            {26'd0, tgt_wr, (tgt_wr ? tgt_addr : 17'd0), (tgt_wr ? tgt_data : 8'd0),
             ioctl_wait, tgt_sel, dl_active, dl_reset, err_flags},
            {26'd0, vq[i].ewr, vq[i].eaddr, vq[i].edata,
             vq[i].ewait, vq[i].esel, vq[i].eact, vq[i].erst, vq[i].eerr});
    end
    // Vector 8 was HOLD entry; HOLD lasts RST_HOLD cycles.
    repeat (RST_HOLD - 1) step();
    check("t1_hold_last", {ioctl_wait, dl_active}, {1'b1, 4'b0010});
    step();
    check("t1_idle", {ioctl_wait, dl_active, dl_reset}, {1'b0, 4'b0000, 1'b0});

    // Index 0: dl_reset and dl_active[0] span rise to end of hold.
    ioctl_download = 1'b1; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    step();
    check("t2_rst_start", {dl_reset, dl_active}, {1'b1, 4'b0001});
    for (int k = 0; k < 3; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = 8'(8'h30 + k);
      step();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    step();                              // s4: enters DRAIN, last byte on tgt_wr
    check("t2_last_byte", {tgt_wr, tgt_data, ioctl_wait}, {1'b1, 8'h32, 1'b1});
    repeat (2) step();                   // s6: HOLD entry
    repeat (RST_HOLD - 1) step();        // last HOLD cycle
    check("t2_rst_hold", {dl_reset, dl_active}, {1'b1, 4'b0001});
    step();
    check("t2_rst_end", {dl_reset, dl_active}, {1'b0, 4'b0000});

    // Index 2, target not ready: wait threshold and full-without-overflow.
    tgt_ready = 4'b1011; ioctl_download = 1'b1; ioctl_index = 8'd2;
    step();
    for (int k = 1; k <= 7; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(17'h100 + k - 1); ioctl_dout = 8'(8'h20 + k - 1);
      step();
      check($sformatf("t3_wait_after_%0d", k), {tgt_wr, ioctl_wait},
            {1'b0, (k >= FIFO_DEPTH - 2) ? 1'b1 : 1'b0});
    end
    ioctl_wr = 1'b0;
    check("t3_no_ovf", {30'd0, err_flags}, 32'd0);
    tgt_ready = 4'hF;
    collect(7, 30);
    check("t3_count", 64'(got_q.size()), 64'd7);
    for (int k = 0; k < got_q.size(); k++)
      check($sformatf("t3_byte%0d", k), 64'(got_q[k]), 64'({17'(17'h100 + k), 8'(8'h20 + k)}));
    end_dl();

    // Overflow: eight fill, ninth dropped, tenth accepted alongside a pop.
    tgt_ready = 4'b1011; ioctl_download = 1'b1; ioctl_index = 8'd2;
    step();
    for (int k = 0; k < 8; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = 8'(8'h40 + k);
      step();
    end
    check("t4_full_no_ovf", {ioctl_wait, err_flags}, {1'b1, 2'b00});
    ioctl_addr = 25'd8; ioctl_dout = 8'h48;
    step();
    check("t4_ovf", {tgt_wr, err_flags}, {1'b0, 2'b01});
    ioctl_addr = 25'd9; ioctl_dout = 8'h49; tgt_ready = 4'hF;
    step();
    check("t4_first_out", {tgt_wr, tgt_data}, {1'b1, 8'h40});
    ioctl_wr = 1'b0;
    collect(8, 30);
    check("t4_count", 64'(got_q.size()), 64'd8);
    for (int k = 0; k < got_q.size(); k++)
      check($sformatf("t4_byte%0d", k + 1), 64'(got_q[k][7:0]),
            64'((k < 7) ? 8'(8'h41 + k) : 8'h49));
    end_dl();

    // Out-of-range index: writes discarded, bad-index flag set.
    ioctl_download = 1'b1; ioctl_index = 8'd7;
    step();
    for (int k = 0; k < 4; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = 8'(8'h70 + k);
      step();
      check($sformatf("t5_discard%0d", k), {tgt_wr, ioctl_wait, dl_active, err_flags},
            {1'b0, 1'b0, 4'b0000, 2'b11});
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    step();

    // Back in IDLE: next download starts at once; checksum bytes FF FF 03.
    ioctl_download = 1'b1; ioctl_index = 8'd3;
    step();
    check("t6_start", {tgt_sel, dl_active, dl_reset}, {4'b1000, 4'b1000, 1'b0});
    for (int k = 0; k < 3; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = (k < 2) ? 8'hFF : 8'h03;
      step();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (4) step();
    check("t6_checksum", 64'(checksum), 64'(exp_ck));
    repeat (RST_HOLD + 5) step();

    // Reset in the middle of a download with bytes stuck in the FIFO.
    tgt_ready = 4'b0000; ioctl_download = 1'b1; ioctl_index = 8'd0;
    step();
    for (int k = 0; k < 2; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = 8'(8'h90 + k);
      step();
    end
    ioctl_wr = 1'b0;
    check("t7_pre_reset", {dl_reset, dl_active}, {1'b1, 4'b0001});
    reset_n = 1'b0;
    step();
    check("t7_reset",
          {ioctl_wait, tgt_sel, tgt_wr, tgt_addr, tgt_data, dl_active, dl_reset, err_flags, checksum},
          64'h0);
    ioctl_download = 1'b0; tgt_ready = 4'hF;
    reset_n = 1'b1;
    collect(1, 6);
    check("t7_fifo_flushed", 64'(got_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
